// File: rtl/boreal_replay_read_arbiter.sv
// boreal_replay_read_arbiter
// Shares the single synchronous read port of the 1024 x 48 telemetry replay
// ledger between the host extractor (req_i[0]) and the replay engine
// (req_i[1]). Each granted request is served as the newest L entries,
// oldest first, on a valid/ready stream. Ledger writes are snooped to mirror
// the write pointer and fill level, and to flag words that were overwritten
// before they were read.
//
// Ports
//   clk_i, rst_ni     clock, synchronous active-low reset
//   wr_valid_i        ledger write strobe (one entry per cycle)
//   req_i[1:0]        burst requests, held until granted
//   len0_i, len1_i    requested burst lengths (host / replay), 0..2^ADDR_W
//   gnt_o[1:0]        one-hot grant, high from GRANT through DONE
//   bram_addr_o       ledger read address
//   bram_rdata_i      ledger read data, one cycle after the address
//   out_data_o, out_valid_o, out_ready_i, out_last_o   burst stream
//   out_overrun_o     sticky per-burst overwrite flag
//   done_o            one-cycle pulse at burst end
//   busy_o            high whenever not idle
module boreal_replay_read_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 48
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  input  logic [1:0]        req_i,
  input  logic [ADDR_W:0]   len0_i,
  input  logic [ADDR_W:0]   len1_i,
  output logic [1:0]        gnt_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              out_overrun_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;   // 1 = replay was served last
  logic                owner_q, owner_d;       // 1 = replay owns the burst
  logic                hold_q, hold_d;         // blocks arbitration right after DONE
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W:0]     k_q, k_d;
  logic [ADDR_W:0]     w_q, w_d;               // writes since grant, saturating
  logic                ovr_q, ovr_d;
  logic                infl_q, infl_d;         // read issued last cycle
  logic                infl_last_q, infl_last_d;
  logic [1:0]          q_cnt_q, q_cnt_d;
  logic [DATA_W-1:0]   q_data0_q, q_data0_d, q_data1_q, q_data1_d;
  logic                q_last0_q, q_last0_d, q_last1_q, q_last1_d;

  logic                win;
  logic [ADDR_W:0]     len_sel, len_clamp, len_eff;
  logic                pop, push, issue;
  logic [2:0]          occ;
  logic [ADDR_W+1:0]   w_eff, thr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      hold_q      <= 1'b0;
      wptr_q      <= '0;
      fill_q      <= '0;
      len_q       <= '0;
      start_q     <= '0;
      k_q         <= '0;
      w_q         <= '0;
      ovr_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      q_cnt_q     <= '0;
      q_data0_q   <= '0;
      q_data1_q   <= '0;
      q_last0_q   <= 1'b0;
      q_last1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      len_q       <= len_d;
      start_q     <= start_d;
      k_q         <= k_d;
      w_q         <= w_d;
      ovr_q       <= ovr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      q_cnt_q     <= q_cnt_d;
      q_data0_q   <= q_data0_d;
      q_data1_q   <= q_data1_d;
      q_last0_q   <= q_last0_d;
      q_last1_q   <= q_last1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    len_d       = len_q;
    start_d     = start_q;
    k_d         = k_q;
    w_d         = w_q;
    ovr_d       = ovr_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    q_cnt_d     = q_cnt_q;
    q_data0_d   = q_data0_q;
    q_data1_d   = q_data1_q;
    q_last0_d   = q_last0_q;
    q_last1_d   = q_last1_q;
    issue       = 1'b0;

    win       = (req_i == 2'b11) ? ~rr_last_q : req_i[1];
    len_sel   = win ? len1_i : len0_i;
    len_clamp = (len_sel > DEPTH_L) ? DEPTH_L : len_sel;
    len_eff   = (len_clamp < fill_q) ? len_clamp : fill_q;

    // Write mirror, independent of the burst state.
    if (wr_valid_i) begin
      wptr_d = wptr_q + 1'b1;
      if (fill_q != DEPTH_L) fill_d = fill_q + 1'b1;
      if (w_q != '1) w_d = w_q + 1'b1;
    end

    // W as it stands including a write landing in this very cycle.
    w_eff = {1'b0, w_q} + {{(ADDR_W+1){1'b0}}, wr_valid_i};
    thr   = {1'b0, DEPTH_L} - {1'b0, len_q} + {1'b0, k_q};

    // Credit check counts the slot freed by this cycle's pop so that a
    // continuously ready sink sees one word per cycle.
    pop  = (q_cnt_q != 2'd0) && out_ready_i;
    push = infl_q;
    occ  = {1'b0, q_cnt_q} - {2'b00, pop} + {2'b00, infl_q};

    case (state_q)
      S_IDLE: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (|req_i) begin
          owner_d   = win;
          rr_last_d = win;
          len_d     = len_eff;
          start_d   = wptr_q - len_eff[ADDR_W-1:0];
          k_d       = '0;
          // The write sampled alongside the latch is the first one that can
          // land on the oldest latched entry.
          w_d       = {{ADDR_W{1'b0}}, wr_valid_i};
          ovr_d     = 1'b0;
          state_d   = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = (len_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if ((k_q != len_q) && (occ < 3'd2)) begin
          issue       = 1'b1;
          k_d         = k_q + 1'b1;
          infl_d      = 1'b1;
          infl_last_d = (k_q == len_q - 1'b1);
          if (w_eff > thr) ovr_d = 1'b1;
        end
        if (pop && q_last0_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        hold_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10: begin
        if (q_cnt_q == 2'd0) begin
          q_data0_d = bram_rdata_i;
          q_last0_d = infl_last_q;
        end else begin
          q_data1_d = bram_rdata_i;
          q_last1_d = infl_last_q;
        end
        q_cnt_d = q_cnt_q + 2'd1;
      end
      2'b01: begin
        q_data0_d = q_data1_q;
        q_last0_d = q_last1_q;
        q_cnt_d   = q_cnt_q - 2'd1;
      end
      2'b11: begin
        if (q_cnt_q == 2'd1) begin
          q_data0_d = bram_rdata_i;
          q_last0_d = infl_last_q;
        end else begin
          q_data0_d = q_data1_q;
          q_last0_d = q_last1_q;
          q_data1_d = bram_rdata_i;
          q_last1_d = infl_last_q;
        end
      end
      default: ;
    endcase
  end

  assign gnt_o         = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign bram_addr_o   = (state_q == S_STREAM) ? (start_q + k_q[ADDR_W-1:0]) : '0;
  assign out_data_o    = q_data0_q;
  assign out_valid_o   = (q_cnt_q != 2'd0);
  assign out_last_o    = (q_cnt_q != 2'd0) && q_last0_q;
  assign out_overrun_o = ovr_q;
  assign done_o        = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_boreal_replay_read_arbiter.sv
// tb_boreal_replay_read_arbiter
// Directed bench for boreal_replay_read_arbiter with a behavioural ledger.
// Each ledger write stores {16'hBEEF, seq} where seq counts writes since
// reset, so the newest L entries are the consecutive seqs ending at the last
// write.
module tb_boreal_replay_read_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [AW:0]   len0 = '0;
  logic [AW:0]   len1 = '0;
  logic [1:0]    gnt;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          out_overrun;
  logic          done;
  logic          busy;

  boreal_replay_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wr_valid_i    (wr_valid),
    .req_i         (req),
    .len0_i        (len0),
    .len1_i        (len1),
    .gnt_o         (gnt),
    .bram_addr_o   (bram_addr),
    .bram_rdata_i  (bram_rdata),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_last_o    (out_last),
    .out_overrun_o (out_overrun),
    .done_o        (done),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Ledger model: synchronous write and read-first synchronous read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wp;
  logic [31:0]   wseq;
  always @(posedge clk) begin
    if (!rst_n) begin
      wp   <= '0;
      wseq <= '0;
    end else if (wr_valid) begin
      mem[wp] <= {16'hBEEF, wseq};
      wp      <= wp + 1'b1;
      wseq    <= wseq + 1;
    end
    bram_rdata <= mem[bram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_writes(input int n);
    wr_valid = 1'b1;
    repeat (n) tick();
    wr_valid = 1'b0;
  endtask

  logic [1:0] r_gnt, r_gnt_after;
  logic       r_ovr_last, r_ovr_done, r_busy_after, r_timeout;
  int         r_words, r_data_err, r_last_err, r_stab_err, r_gap_err;
  int         r_valid_seen, r_lat, r_done_cyc;

  task automatic do_burst(input string tag, input logic [1:0] rq, input logic [1:0] rq_after,
                          input logic [AW:0] l0, input logic [AW:0] l1,
                          input int rdy_mode, input bit wr_on, input bit chk_data,
                          input int exp_base, input int exp_n, input int exp_a0);
    int  acyc, vcyc, lastv;
    bit  got, fin, prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    r_gnt = '0; r_words = 0; r_data_err = 0; r_last_err = 0; r_stab_err = 0;
    r_gap_err = 0; r_valid_seen = 0; r_lat = -1; r_done_cyc = -1;
    r_ovr_last = 1'b0; r_ovr_done = 1'b0; r_timeout = 1'b0;
    acyc = -1; vcyc = -1; lastv = -1; got = 0; fin = 0; prev_stall = 0;
    prev_last = 0; prev_data = '0;
    req = rq; len0 = l0; len1 = l1;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (gnt != 2'b00) begin
        got = 1;
        r_gnt = gnt;
        req = rq_after;
      end
    end
    if (got) begin
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
        if (cyc != 0) tick();
        wr_valid  = wr_on;
        out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
        if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
          r_stab_err++;
        if (acyc < 0 && bram_addr == AW'(exp_a0)) acyc = cyc;
        if (out_valid) begin
          r_valid_seen = 1;
          if (vcyc < 0) vcyc = cyc;
        end
        if (out_valid && out_ready) begin
          if (rdy_mode == 0 && lastv >= 0 && cyc != lastv + 1) r_gap_err++;
          lastv = cyc;
          if (chk_data && out_data !== {16'hBEEF, 32'(exp_base + r_words)}) r_data_err++;
          if (out_last !== (r_words == exp_n - 1)) r_last_err++;
          if (out_last) r_ovr_last = out_overrun;
          r_words++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (done) begin
          fin = 1;
          r_done_cyc = cyc;
          r_ovr_done = out_overrun;
        end
      end
    end
    wr_valid  = 1'b0;
    out_ready = 1'b0;
    req       = 2'b00;
    r_timeout = !(got && fin);
    if (acyc >= 0 && vcyc >= 0) r_lat = vcyc - acyc;
    tick();
    r_gnt_after  = gnt;
    r_busy_after = busy;
    chk({tag, "_timeout"}, 64'(r_timeout), 64'd0);
  endtask

  initial begin
    int n;
    bit got;
    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_ovr", 64'(out_overrun), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: 5 writes, host len 3 -> seqs 2,3,4 from addresses 2..4.
    do_writes(5);
    do_burst("t1", 2'b01, 2'b00, 11'd3, 11'd0, 0, 0, 1, 2, 3, 2);
    chk("t1_gnt", 64'(r_gnt), 64'd1);
    chk("t1_words", 64'(r_words), 64'd3);
    chk("t1_data", 64'(r_data_err), 64'd0);
    chk("t1_last", 64'(r_last_err), 64'd0);
    chk("t1_ovr", 64'(r_ovr_last), 64'd0);
    chk("t1_gnt_after", 64'(r_gnt_after), 64'd0);
    chk("t1_busy_after", 64'(r_busy_after), 64'd0);

    // 2: 4 writes, replay len 10 -> clipped to fill = 4.
    do_reset();
    do_writes(4);
    do_burst("t2", 2'b10, 2'b00, 11'd0, 11'd10, 0, 0, 1, 0, 4, 0);
    chk("t2_gnt", 64'(r_gnt), 64'd2);
    chk("t2_words", 64'(r_words), 64'd4);
    chk("t2_data", 64'(r_data_err), 64'd0);
    chk("t2_last", 64'(r_last_err), 64'd0);
    // L = 0 after reset with no writes.
    do_reset();
    do_burst("t2z", 2'b10, 2'b00, 11'd0, 11'd5, 0, 0, 1, 0, 0, 0);
    chk("t2z_done_cyc", 64'(r_done_cyc), 64'd1);
    chk("t2z_valid", 64'(r_valid_seen), 64'd0);
    chk("t2z_ovr", 64'(r_ovr_done), 64'd0);

    // 3: tie arbitration.
    do_reset();
    do_writes(3);
    do_burst("t3a", 2'b11, 2'b10, 11'd1, 11'd2, 0, 0, 1, 2, 1, 2);
    chk("t3a_gnt", 64'(r_gnt), 64'd1);
    do_burst("t3b", 2'b10, 2'b00, 11'd1, 11'd2, 0, 0, 1, 1, 2, 1);
    chk("t3b_gnt", 64'(r_gnt), 64'd2);
    chk("t3b_data", 64'(r_data_err), 64'd0);
    do_burst("t3c", 2'b11, 2'b00, 11'd1, 11'd2, 0, 0, 1, 2, 1, 2);
    chk("t3c_gnt", 64'(r_gnt), 64'd1);
    do_burst("t3d", 2'b11, 2'b00, 11'd1, 11'd2, 0, 0, 1, 1, 2, 1);
    chk("t3d_gnt", 64'(r_gnt), 64'd2);

    // 4: wrapped read, 1030 writes, host len 8 -> addresses 1022,1023,0..5.
    do_reset();
    do_writes(1030);
    do_burst("t4", 2'b01, 2'b00, 11'd8, 11'd0, 0, 0, 1, 1022, 8, 1022);
    chk("t4_words", 64'(r_words), 64'd8);
    chk("t4_data", 64'(r_data_err), 64'd0);
    chk("t4_last", 64'(r_last_err), 64'd0);
    chk("t4_gap", 64'(r_gap_err), 64'd0);
    chk("t4_lat", 64'(r_lat), 64'd2);
    do_burst("t4r", 2'b01, 2'b00, 11'd8, 11'd0, 1, 0, 1, 1022, 8, 1022);
    chk("t4r_words", 64'(r_words), 64'd8);
    chk("t4r_data", 64'(r_data_err), 64'd0);
    chk("t4r_last", 64'(r_last_err), 64'd0);
    chk("t4r_stable", 64'(r_stab_err), 64'd0);

    // 5: full-ledger bursts.
    do_burst("t5a", 2'b01, 2'b00, 11'd1024, 11'd0, 0, 0, 1, 6, 1024, 6);
    chk("t5a_words", 64'(r_words), 64'd1024);
    chk("t5a_data", 64'(r_data_err), 64'd0);
    chk("t5a_ovr", 64'(r_ovr_last), 64'd0);
    do_burst("t5c", 2'b01, 2'b00, 11'd2000, 11'd0, 0, 0, 1, 6, 1024, 6);
    chk("t5c_words", 64'(r_words), 64'd1024);
    chk("t5c_last", 64'(r_last_err), 64'd0);
    do_burst("t5w", 2'b01, 2'b00, 11'd1024, 11'd0, 0, 1, 0, 0, 1024, 6);
    chk("t5w_words", 64'(r_words), 64'd1024);
    chk("t5w_ovr", 64'(r_ovr_last), 64'd1);
    chk("t5w_ovr_done", 64'(r_ovr_done), 64'd1);

    // 6: reset in the middle of a burst.
    req = 2'b01; len0 = 11'd8; got = 0; n = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (gnt != 2'b00) got = 1;
    end
    req = 2'b00; out_ready = 1'b1;
    for (int c = 0; c < 50 && n < 3; c++) begin
      tick();
      if (out_valid && out_ready) n++;
    end
    chk("t6_pre_words", 64'(n), 64'd3);
    rst_n = 1'b0;
    tick();
    chk("t6_gnt", 64'(gnt), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    rst_n = 1'b1; out_ready = 1'b0;
    tick();
    do_writes(2);
    do_burst("t6b", 2'b01, 2'b00, 11'd10, 11'd0, 0, 0, 1, 0, 2, 0);
    chk("t6b_words", 64'(r_words), 64'd2);
    chk("t6b_data", 64'(r_data_err), 64'd0);
    chk("t6b_last", 64'(r_last_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
